// File: rtl/jeff_181_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jeff_181_nibble_sequencer
// Purpose  : Runs a 4*NIB-bit operation through one external 4-bit 74x181
//            ALU slice, one nibble per clock. The carry ripples through a
//            register between nibbles, and the per-nibble A=B flags are ANDed.
// Ports    : clk, rst (sync, active-high)
//            start, a, b, s, m, ci  - operation request and operands
//            busy, done, f, co, aeqb - status and assembled result
//            alu_a/b/s/m/ci (out), alu_f/co/aeqb (in) - ALU slice interface
// Revision : 1.0 - initial release
// ============================================================================
module jeff_181_nibble_sequencer #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] f,
    output logic             co,
    output logic             aeqb,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_ci,
    input  logic [3:0]       alu_f,
    input  logic             alu_co,
    input  logic             alu_aeqb
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [4*NIB-1:0] a_q, a_d;
    logic [4*NIB-1:0] b_q, b_d;
    logic             acc_q, acc_d;
    logic [4*NIB-1:0] f_q, f_d;
    logic             co_q, co_d;
    logic             aeqb_q, aeqb_d;
    // The ALU-side outputs are registers so they hold their last value in
    // IDLE/DONE. alu_s_q/alu_m_q double as the latched s and m, and
    // alu_ci_q is the inter-nibble carry register.
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_s_q, alu_s_d;
    logic             alu_m_q, alu_m_d;
    logic             alu_ci_q, alu_ci_d;

    logic [IW-1:0]    cnt_nxt;
    logic             last_nib;

    assign cnt_nxt  = cnt_q + 1'b1;
    assign last_nib = (cnt_q == IW'(NIB - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        f_d      = f_q;
        co_d     = co_q;
        aeqb_d   = aeqb_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_s_d  = alu_s_q;
        alu_m_d  = alu_m_q;
        alu_ci_d = alu_ci_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = '0;
                    acc_d    = 1'b1;
                    // Present nibble 0 straight away so the first RUN edge
                    // already captures a valid ALU result.
                    alu_a_d  = a[3:0];
                    alu_b_d  = b[3:0];
                    alu_s_d  = s;
                    alu_m_d  = m;
                    alu_ci_d = ci;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (cnt_q == IW'(i)) begin
                        f_d[4*i +: 4] = alu_f;
                    end
                end
                acc_d = acc_q & alu_aeqb;
                if (last_nib) begin
                    // Keep the ALU inputs frozen on the final nibble; the
                    // final carry goes to co instead.
                    co_d    = alu_co;
                    aeqb_d  = acc_q & alu_aeqb;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d    = cnt_nxt;
                    alu_ci_d = alu_co;
                    for (int i = 0; i < NIB; i++) begin
                        if (cnt_nxt == IW'(i)) begin
                            alu_a_d = a_q[4*i +: 4];
                            alu_b_d = b_q[4*i +: 4];
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= 1'b0;
            f_q      <= '0;
            co_q     <= 1'b0;
            aeqb_q   <= 1'b0;
            alu_a_q  <= 4'h0;
            alu_b_q  <= 4'h0;
            alu_s_q  <= 4'h0;
            alu_m_q  <= 1'b0;
            alu_ci_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            f_q      <= f_d;
            co_q     <= co_d;
            aeqb_q   <= aeqb_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_s_q  <= alu_s_d;
            alu_m_q  <= alu_m_d;
            alu_ci_q <= alu_ci_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign f      = f_q;
    assign co     = co_q;
    assign aeqb   = aeqb_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_s  = alu_s_q;
    assign alu_m  = alu_m_q;
    assign alu_ci = alu_ci_q;

endmodule
`default_nettype wire

// File: tb/tb_jeff_181_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jeff_181_nibble_sequencer
// Purpose  : Self-checking bench for jeff_181_nibble_sequencer. A behavioural
//            74x181 slice (active-high data, active-low carry) is attached to
//            the ALU-side ports; results are compared with a word-wide model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jeff_181_nibble_sequencer;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         m, ci;
    logic         busy, done, co, aeqb;
    logic [W-1:0] f;
    logic [3:0]   alu_a, alu_b, alu_s, alu_f;
    logic         alu_m, alu_ci, alu_co, alu_aeqb;

    int checks   = 0;
    int failures = 0;

    jeff_181_nibble_sequencer #(.NIB(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .s        (s),
        .m        (m),
        .ci       (ci),
        .busy     (busy),
        .done     (done),
        .f        (f),
        .co       (co),
        .aeqb     (aeqb),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_m    (alu_m),
        .alu_ci   (alu_ci),
        .alu_f    (alu_f),
        .alu_co   (alu_co),
        .alu_aeqb (alu_aeqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74x181 slice: F = Y plus X plus carry, where Y/X are the two
    // select-controlled first-level terms. Logic mode is XNOR of those terms.
    function automatic logic [5:0] alu181(input logic [3:0] xa, input logic [3:0] xb,
                                          input logic [3:0] xs, input logic xm,
                                          input logic xcn);
        logic [3:0] y, x, fo;
        logic [4:0] sum;
        y   = xa | (xb & {4{xs[0]}}) | (~xb & {4{xs[1]}});
        x   = (xa & ~xb & {4{xs[2]}}) | (xa & xb & {4{xs[3]}});
        sum = {1'b0, y} + {1'b0, x} + {4'b0, ~xcn};
        fo  = xm ? ~(y ^ x) : sum[3:0];
        return {&fo, ~sum[4], fo};
    endfunction

    always_comb {alu_aeqb, alu_co, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_ci);

    // Whole-word reference: the full-width sum carries through every nibble,
    // so the word carry equals the carry out of the last slice in both modes.
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                             input logic [3:0] rs, input logic rm, input logic rci,
                             output logic [W-1:0] ef, output logic eco,
                             output logic eaeq);
        logic [W-1:0] y, x;
        logic [W:0]   sum;
        y    = ra | (rb & {W{rs[0]}}) | (~rb & {W{rs[1]}});
        x    = (ra & ~rb & {W{rs[2]}}) | (ra & rb & {W{rs[3]}});
        sum  = {1'b0, y} + {1'b0, x} + {{W{1'b0}}, ~rci};
        ef   = rm ? ~(y ^ x) : sum[W-1:0];
        eco  = ~sum[W];
        eaeq = &ef;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full operation with operand scrambling after acceptance.
    task automatic run_op(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [3:0] vs, input logic vm, input logic vci,
                          input logic [W-1:0] ef, input logic eco, input logic eaeq);
        @(negedge clk);
        a = va; b = vb; s = vs; m = vm; ci = vci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom); ci = 1'($urandom);
        chk({nm, " busy0"}, 32'(busy), 32'd1);
        chk({nm, " done0"}, 32'(done), 32'd0);
        chk({nm, " alu_a0"}, 32'(alu_a), 32'(va[3:0]));
        chk({nm, " alu_ci0"}, 32'(alu_ci), 32'(vci));
        chk({nm, " alu_m0"}, 32'(alu_m), 32'(vm));
        for (int i = 1; i < NIB; i++) begin
            @(negedge clk);
            chk({nm, " busy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " f"}, 32'(f), 32'(ef));
        chk({nm, " co"}, 32'(co), 32'(eco));
        chk({nm, " aeqb"}, 32'(aeqb), 32'(eaeq));
        chk({nm, " alu_s_hold"}, 32'(alu_s), 32'(vs));
        chk({nm, " alu_a_last"}, 32'(alu_a), 32'(va[W-1:W-4]));
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(done), 32'd0);
        chk({nm, " f_hold"}, 32'(f), 32'(ef));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         ci;
        logic [W-1:0] ef;
        logic         eco;
        logic         eaeq;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] ef;
        logic         eco, eaeq;
        int           ndone;

        vecs[0] = '{16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hFF00, 1'b0, 1'b0}; // XOR
        vecs[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}; // full ripple
        vecs[2] = '{16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0}; // add, no carry
        vecs[3] = '{16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1}; // equal
        vecs[4] = '{16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0}; // not equal
        vecs[5] = '{16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0}; // carry in
        vecs[6] = '{16'h5678, 16'h1234, 4'b0110, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0}; // subtract
        vecs[7] = '{16'hA5A5, 16'h1234, 4'b0000, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0}; // NOT A
        vecs[8] = '{16'h0001, 16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0}; // logic-mode carry

        // Reset, with start asserted to confirm reset wins.
        rst = 1'b1; start = 1'b1;
        a = 16'hFFFF; b = 16'hFFFF; s = 4'hF; m = 1'b1; ci = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst f", 32'(f), 32'd0);
        chk("rst co", 32'(co), 32'd0);
        chk("rst aeqb", 32'(aeqb), 32'd0);
        chk("rst alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_ci}), 32'd0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m,
                   vecs[i].ci, vecs[i].ef, vecs[i].eco, vecs[i].eaeq);
        end

        // Abort: reset sampled at the RUN edge with cnt=2.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; s = 4'b1001; m = 1'b0; ci = 1'b1; start = 1'b1;
        @(negedge clk);   // after E0, cnt=0
        start = 1'b0;
        @(negedge clk);   // after E1, cnt=1
        @(negedge clk);   // after E2, cnt=2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort f", 32'(f), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);

        // Start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; s = 4'b1001; m = 1'b0; ci = 1'b1; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a = 16'hFFFF; b = 16'h0001; s = 4'b0110; m = 1'b1; ci = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                chk("ignore f", 32'(f), 32'h5555);
                chk("ignore co", 32'(co), 32'd1);
                start = 1'b1;
            end
        end
        start = 1'b0;
        chk("ignore one done", 32'(ndone), 32'd1);

        // Randomized operations against the word-level model.
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra, rb;
            logic [3:0]   rs;
            logic         rm, rci;
            ra = W'($urandom); rb = W'($urandom);
            rs = 4'($urandom_range(0, 15)); rm = 1'($urandom); rci = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            ref_model(ra, rb, rs, rm, rci, ef, eco, eaeq);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rm, rci, ef, eco, eaeq);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
